// File: rtl/uart_frame_serializer_if.sv
// Byte-stream handshake bundle for the frame serializer: the upstream word
// port (valid/ready) and the downstream UART byte port (valid/ready).
// The master side is whoever supplies words and consumes bytes; the slave
// side is the serializer itself.
interface uart_frame_serializer_if #(
  parameter int DATA_BYTES = 7
);
  logic [8*DATA_BYTES-1:0] i_FRAME_DATA;
  logic                    i_FRAME_VALID;
  logic                    o_FRAME_READY;
  logic [7:0]              o_TX_BYTE;
  logic                    o_TX_BYTE_VALID;
  logic                    i_TX_BYTE_READY;

  modport master (
    output i_FRAME_DATA,
    output i_FRAME_VALID,
    output i_TX_BYTE_READY,
    input  o_FRAME_READY,
    input  o_TX_BYTE,
    input  o_TX_BYTE_VALID
  );

  modport slave (
    input  i_FRAME_DATA,
    input  i_FRAME_VALID,
    input  i_TX_BYTE_READY,
    output o_FRAME_READY,
    output o_TX_BYTE,
    output o_TX_BYTE_VALID
  );
endinterface

// File: rtl/uart_frame_serializer.sv
// Serializes one payload word into SYNC, payload bytes (MSB first) and an
// XOR checksum byte for the UART transmitter, then idles for an
// inter-frame gap before taking the next word.
//
// state  | meaning
// IDLE   | ready for a word, no byte presented
// SYNC   | presenting the sync header byte
// DATA   | presenting payload bytes, folding each accepted one into csum
// CSUM   | presenting the XOR of all payload bytes
// GAP    | inter-frame idle, no word accepted, no byte presented
module uart_frame_serializer #(
  parameter int         DATA_BYTES = 7,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         IFG_CYCLES = 4
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  uart_frame_serializer_if.slave        bus,
  output logic                          o_BUSY,
  output logic [15:0]                   o_FRAME_CNT
);

  localparam int W  = 8 * DATA_BYTES;
  localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BYTES - 1);
  localparam logic [GW-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GW'(IFG_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_CSUM,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [7:0]    csum_q, csum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_valid_q, tx_valid_d;
  logic          ready_q, ready_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  // Next-state and next-output decode; every byte presented is registered
  // so nothing on the input side reaches an output combinationally.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    tx_byte_d   = tx_byte_q;
    tx_valid_d  = tx_valid_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (ready_q && bus.i_FRAME_VALID) begin
          state_d    = S_SYNC;
          shift_d    = bus.i_FRAME_DATA;
          csum_d     = '0;
          idx_d      = '0;
          tx_byte_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
        end
      end
      S_SYNC: begin
        if (bus.i_TX_BYTE_READY) begin
          state_d   = S_DATA;
          tx_byte_d = shift_q[W-1 -: 8];
        end
      end
      S_DATA: begin
        if (bus.i_TX_BYTE_READY) begin
          csum_d  = csum_q ^ shift_q[W-1 -: 8];
          shift_d = shift_q << 8;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d   = S_CSUM;
            tx_byte_d = csum_d;
          end else begin
            tx_byte_d = shift_d[W-1 -: 8];
          end
        end
      end
      S_CSUM: begin
        if (bus.i_TX_BYTE_READY) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          tx_valid_d  = 1'b0;
          if (IFG_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    // Ready is registered from the upcoming state so it is low throughout
    // reset and rises on the first edge after reset is released.
    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers with synchronous reset; reset aborts any
  // frame in flight without emitting its checksum.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      csum_q      <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      tx_byte_q   <= '0;
      tx_valid_q  <= 1'b0;
      ready_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      tx_byte_q   <= tx_byte_d;
      tx_valid_q  <= tx_valid_d;
      ready_q     <= ready_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.o_FRAME_READY   = ready_q;
  assign bus.o_TX_BYTE       = tx_byte_q;
  assign bus.o_TX_BYTE_VALID = tx_valid_q;
  assign o_BUSY              = (state_q != S_IDLE);
  assign o_FRAME_CNT         = frame_cnt_q;

endmodule

// File: tb/tb_uart_frame_serializer.sv
// Bench for uart_frame_serializer: instance 0 uses the default 4-cycle gap,
// instance 1 uses no gap. A byte-level model (expected byte FIFO built from
// each accepted word) tracks every handshake and the frame counter.
module tb_uart_frame_serializer;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        busy_a, busy_b;
  logic [15:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  uart_frame_serializer_if #(.DATA_BYTES(7)) ifa ();
  uart_frame_serializer_if #(.DATA_BYTES(7)) ifb ();

  uart_frame_serializer #(.DATA_BYTES(7), .SYNC_BYTE(8'hA5), .IFG_CYCLES(4)) dut_a (
    .i_CLK(clk), .i_RST(rst_a), .bus(ifa), .o_BUSY(busy_a), .o_FRAME_CNT(cnt_a)
  );

  uart_frame_serializer #(.DATA_BYTES(7), .SYNC_BYTE(8'hA5), .IFG_CYCLES(0)) dut_b (
    .i_CLK(clk), .i_RST(rst_b), .bus(ifb), .o_BUSY(busy_b), .o_FRAME_CNT(cnt_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ifg[2];

  logic        d_rst[2], d_fv[2], d_txr[2];
  logic [55:0] d_fd[2];
  logic        s_vld[2], s_rdy[2], s_busy[2];
  logic [7:0]  s_byte[2];
  logic [15:0] s_cnt[2];

  logic [8:0]  exp_mem[2][0:63];
  int          wr[2], rd[2];
  logic [15:0] exp_cnt[2];
  bit          hold[2], gap_on[2], cnt_chk[2], rst_seen[2], acc_flag[2];
  bit          auto_en[2], start_en[2];
  logic [7:0]  hold_byte[2];
  int          gap_k[2], mode[2];
  int          last_acc_cyc[2], last_csum_cyc[2];
  logic [7:0]  log_mem[2][0:63];
  int          log_n[2];
  logic [7:0]  basic_seq[9];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic apply();
    rst_a               = d_rst[0];
    rst_b               = d_rst[1];
    ifa.i_FRAME_VALID   = d_fv[0];
    ifa.i_FRAME_DATA    = d_fd[0];
    ifa.i_TX_BYTE_READY = d_txr[0];
    ifb.i_FRAME_VALID   = d_fv[1];
    ifb.i_FRAME_DATA    = d_fd[1];
    ifb.i_TX_BYTE_READY = d_txr[1];
  endtask

  task automatic snap();
    s_vld[0]  = ifa.o_TX_BYTE_VALID;
    s_rdy[0]  = ifa.o_FRAME_READY;
    s_byte[0] = ifa.o_TX_BYTE;
    s_busy[0] = busy_a;
    s_cnt[0]  = cnt_a;
    s_vld[1]  = ifb.o_TX_BYTE_VALID;
    s_rdy[1]  = ifb.o_FRAME_READY;
    s_byte[1] = ifb.o_TX_BYTE;
    s_busy[1] = busy_b;
    s_cnt[1]  = cnt_b;
  endtask

  task automatic put(input int d, input logic [8:0] v);
    exp_mem[d][wr[d] % 64] = v;
    wr[d]++;
  endtask

  // Expected frame: sync, payload bytes MSB first, XOR of payload bytes.
  task automatic push_frame(input int d, input logic [55:0] data);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    put(d, {1'b0, 8'hA5});
    for (int i = 0; i < 7; i++) begin
      b  = data[55 - 8*i -: 8];
      cs = cs ^ b;
      put(d, {1'b0, b});
    end
    put(d, {1'b1, cs});
  endtask

  // Handshakes about to happen on the coming rising edge.
  task automatic eval();
    logic [8:0] e;
    for (int d = 0; d < 2; d++) begin
      acc_flag[d] = 1'b0;
      hold[d]     = 1'b0;
      if (d_rst[d]) continue;
      if (s_vld[d] && d_txr[d]) begin
        chk($sformatf("byte_expected[%0d]", d), (wr[d] != rd[d]), 1);
        if (wr[d] != rd[d]) begin
          e = exp_mem[d][rd[d] % 64];
          rd[d]++;
          chk($sformatf("tx_byte[%0d]", d), s_byte[d], e[7:0]);
          log_mem[d][log_n[d] % 64] = s_byte[d];
          log_n[d]++;
          if (e[8]) begin
            exp_cnt[d]       = exp_cnt[d] + 16'd1;
            cnt_chk[d]       = 1'b1;
            gap_on[d]        = 1'b1;
            gap_k[d]         = 0;
            last_csum_cyc[d] = cyc;
          end
        end
      end
      hold[d]      = s_vld[d] && !d_txr[d];
      hold_byte[d] = s_byte[d];
      if (d_fv[d] && s_rdy[d]) begin
        push_frame(d, d_fd[d]);
        acc_flag[d]     = 1'b1;
        last_acc_cyc[d] = cyc;
      end
    end
  endtask

  task automatic step();
    logic [63:0] r;
    apply();
    snap();
    eval();
    @(negedge clk);
    cyc++;
    snap();
    for (int d = 0; d < 2; d++) begin
      if (d_rst[d]) begin
        chk($sformatf("rst_valid[%0d]", d), s_vld[d], 0);
        chk($sformatf("rst_ready[%0d]", d), s_rdy[d], 0);
        chk($sformatf("rst_busy[%0d]", d), s_busy[d], 0);
        chk($sformatf("rst_cnt[%0d]", d), s_cnt[d], 0);
        chk($sformatf("rst_byte[%0d]", d), s_byte[d], 0);
        rd[d]       = wr[d];
        exp_cnt[d]  = 16'd0;
        gap_on[d]   = 1'b0;
        cnt_chk[d]  = 1'b0;
        rst_seen[d] = 1'b1;
        continue;
      end
      if (rst_seen[d]) begin
        chk($sformatf("ready_after_rst[%0d]", d), s_rdy[d], 1);
        rst_seen[d] = 1'b0;
      end
      if (hold[d])
        chk($sformatf("byte_hold[%0d]", d), {s_vld[d], s_byte[d]}, {1'b1, hold_byte[d]});
      chk($sformatf("valid_in_frame[%0d]", d), s_vld[d], (wr[d] != rd[d]));
      if (wr[d] != rd[d])
        chk($sformatf("busy_in_frame[%0d]", d), s_busy[d], 1);
      if (cnt_chk[d]) begin
        chk($sformatf("frame_cnt[%0d]", d), s_cnt[d], exp_cnt[d]);
        cnt_chk[d] = 1'b0;
      end
      if (gap_on[d]) begin
        gap_k[d]++;
        chk($sformatf("ready_gap[%0d]", d), s_rdy[d], (gap_k[d] == ifg[d] + 1));
        if (gap_k[d] == ifg[d] + 1) begin
          chk($sformatf("idle_after_gap[%0d]", d), s_busy[d], 0);
          gap_on[d] = 1'b0;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      case (mode[d])
        0:       d_txr[d] = 1'b1;
        1:       d_txr[d] = (cyc % 3 == 0);
        default: d_txr[d] = ($urandom_range(0, 2) != 0);
      endcase
      if (auto_en[d]) begin
        if (acc_flag[d]) begin
          d_fv[d] = 1'b0;
        end else if (start_en[d] && !d_fv[d] && $urandom_range(0, 3) == 0) begin
          r       = {$urandom(), $urandom()};
          d_fv[d] = 1'b1;
          d_fd[d] = r[55:0];
        end
      end
    end
  endtask

  task automatic wait_accept(input int d, input int limit);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_flag[d] && n < limit);
    chk($sformatf("accept_in_time[%0d]", d), (n < limit), 1);
  endtask

  task automatic wait_quiet(input int d, input int limit);
    int n;
    n = 0;
    while ((wr[d] != rd[d] || gap_on[d] || d_fv[d]) && n < limit) begin
      step();
      n++;
    end
    chk($sformatf("quiet_in_time[%0d]", d), (n < limit), 1);
  endtask

  task automatic send(input int d, input logic [55:0] data);
    d_fv[d] = 1'b1;
    d_fd[d] = data;
    wait_accept(d, 50);
    d_fv[d] = 1'b0;
    wait_quiet(d, 400);
  endtask

  task automatic check_basic_seq(input string tag);
    chk({tag, "_len"}, log_n[0], 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s_byte%0d", tag, i), log_mem[0][i], basic_seq[i]);
  endtask

  initial begin
    int          n;
    logic [63:0] r;
    logic [7:0]  eb;
    ifg       = '{4, 0};
    basic_seq = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    for (int d = 0; d < 2; d++) begin
      d_rst[d] = 1'b1; d_fv[d] = 1'b0; d_fd[d] = '0; d_txr[d] = 1'b0;
      wr[d] = 0; rd[d] = 0; exp_cnt[d] = '0; log_n[d] = 0; mode[d] = 0;
      hold[d] = 1'b0; gap_on[d] = 1'b0; cnt_chk[d] = 1'b0; rst_seen[d] = 1'b0;
      acc_flag[d] = 1'b0; auto_en[d] = 1'b0; start_en[d] = 1'b0; gap_k[d] = 0;
      last_acc_cyc[d] = 0; last_csum_cyc[d] = 0;
    end

    repeat (3) step();
    d_rst[0] = 1'b0;
    d_rst[1] = 1'b0;
    step();

    // Basic frame with continuous ready.
    log_n[0] = 0;
    mode[0]  = 0;
    send(0, 56'h0123456789ABCD);
    check_basic_seq("basic");
    chk("basic_span", last_csum_cyc[0] - last_acc_cyc[0], 9);
    chk("basic_cnt", s_cnt[0], 1);

    // Same word under backpressure, ready once every three cycles.
    log_n[0] = 0;
    mode[0]  = 1;
    send(0, 56'h0123456789ABCD);
    check_basic_seq("bp");
    chk("bp_cnt", s_cnt[0], 2);

    // A second word offered mid-frame must be ignored.
    log_n[0] = 0;
    mode[0]  = 0;
    d_fv[0]  = 1'b1;
    d_fd[0]  = 56'h0123456789ABCD;
    wait_accept(0, 50);
    d_fv[0] = 1'b0;
    n = 0;
    while (log_n[0] < 3 && n < 50) begin
      step();
      n++;
    end
    chk("busy_reach_data", (n < 50), 1);
    d_fv[0] = 1'b1;
    d_fd[0] = 56'hFFFFFFFFFFFFFF;
    step();
    d_fv[0] = 1'b0;
    d_fd[0] = '0;
    wait_quiet(0, 200);
    check_basic_seq("busy");
    chk("busy_cnt", s_cnt[0], 3);

    // Back-to-back words with no inter-frame gap.
    log_n[1] = 0;
    mode[1]  = 0;
    d_fv[1]  = 1'b1;
    d_fd[1]  = 56'h0;
    wait_accept(1, 50);
    d_fd[1] = 56'h01010101010101;
    wait_accept(1, 50);
    d_fv[1] = 1'b0;
    chk("b2b_accept_gap", last_acc_cyc[1] - last_csum_cyc[1], 1);
    wait_quiet(1, 200);
    chk("b2b_len", log_n[1], 18);
    for (int i = 0; i < 18; i++) begin
      if (i < 9) eb = (i == 0) ? 8'hA5 : 8'h00;
      else       eb = (i == 9) ? 8'hA5 : 8'h01;
      chk($sformatf("b2b_byte%0d", i), log_mem[1][i], eb);
    end
    chk("b2b_cnt", s_cnt[1], 2);

    // Reset after the third payload byte is accepted.
    log_n[0] = 0;
    r        = {$urandom(), $urandom()};
    d_fv[0]  = 1'b1;
    d_fd[0]  = r[55:0];
    wait_accept(0, 50);
    d_fv[0] = 1'b0;
    n = 0;
    while (log_n[0] < 4 && n < 50) begin
      step();
      n++;
    end
    chk("rst_reach_payload3", (n < 50), 1);
    d_rst[0] = 1'b1;
    step();
    d_rst[0] = 1'b0;
    step();
    log_n[0] = 0;
    r        = {$urandom(), $urandom()};
    send(0, r[55:0]);
    chk("post_rst_sync", log_mem[0][0], 8'hA5);
    chk("post_rst_len", log_n[0], 9);
    chk("post_rst_cnt", s_cnt[0], 1);

    // Random traffic and random backpressure on both instances.
    for (int d = 0; d < 2; d++) begin
      mode[d]     = 2;
      auto_en[d]  = 1'b1;
      start_en[d] = 1'b1;
    end
    repeat (3000) step();
    start_en[0] = 1'b0;
    start_en[1] = 1'b0;
    wait_quiet(0, 500);
    wait_quiet(1, 500);
    auto_en[0] = 1'b0;
    auto_en[1] = 1'b0;
    step();
    chk("rand_cnt_a", s_cnt[0], exp_cnt[0]);
    chk("rand_cnt_b", s_cnt[1], exp_cnt[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
